// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit width and the width helpers used for
// buffer pointers and credit counters.
package noc_pkg;

  localparam int unsigned FLIT_SIZE_DEF = 8;

  // Ceiling log2 with a floor of one bit; matches the downstream buffer's pointer sizing.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned w;
    v = (value > 0) ? value - 1 : 0;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

  // Bits needed to hold every credit value from 0 up to depth inclusive.
  function automatic int unsigned credit_width(input int unsigned depth);
    return clogb2(depth + 1);
  endfunction

endpackage

// File: rtl/flit_transmitter_credit_counter.sv
// Saturating up/down credit counter, reset to MAX. Overflow detection is
// present only when FLIT_TRANSMITTER_CREDIT_CHECK_EN is defined.
module credit_counter
  import noc_pkg::*;
#(
  parameter  int unsigned MAX = 8,
  localparam int unsigned W   = credit_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         nonzero,
  output logic         overflow
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_max;

  assign at_max  = (count_q == W'(MAX));
  assign nonzero = (count_q != '0);
  assign count   = count_q;

  // Simultaneous inc and dec cancel; inc at MAX saturates, dec at zero holds.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && !at_max) begin
      count_d = count_q + W'(1);
    end else if (dec && !inc && nonzero) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= W'(MAX);
    end else begin
      count_q <= count_d;
    end
  end

`ifdef FLIT_TRANSMITTER_CREDIT_CHECK_EN
  assign overflow = inc & ~dec & at_max;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: rtl/flit_transmitter.sv
// Credit-based flit sender with a one-flit output register. Optional sticky
// credit-overflow flag enabled by FLIT_TRANSMITTER_CREDIT_CHECK_EN.
module flit_transmitter
  import noc_pkg::*;
#(
  parameter  int unsigned BUFFER_SIZE = 8,
  parameter  int unsigned FLIT_SIZE   = FLIT_SIZE_DEF,
  localparam int unsigned CW          = credit_width(BUFFER_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 write_o,
  input  logic                 credit_i,
  output logic [CW-1:0]        credit_count_o,
  output logic                 error_o
);

  logic                 hold_valid_q;
  logic                 hold_valid_d;
  logic [FLIT_SIZE-1:0] hold_data_q;
  logic [FLIT_SIZE-1:0] hold_data_d;
  logic                 credits_nonzero;
  logic                 credit_overflow;
  logic                 accept;

  // Ready passes through write_o so a new flit loads as the held one leaves.
  assign write_o = hold_valid_q & credits_nonzero;
  assign ready_o = ~hold_valid_q | write_o;
  assign accept  = valid_i & ready_o;
  assign data_o  = hold_data_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = data_i;
    end else if (write_o) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  credit_counter #(
    .MAX (BUFFER_SIZE)
  ) u_credit_counter (
    .clk      (clk),
    .rst      (rst),
    .dec      (write_o),
    .inc      (credit_i),
    .count    (credit_count_o),
    .nonzero  (credits_nonzero),
    .overflow (credit_overflow)
  );

`ifdef FLIT_TRANSMITTER_CREDIT_CHECK_EN
  logic error_q;
  logic error_d;

  always_comb begin
    error_d = error_q | credit_overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`else
  // The counter ties overflow low in this build, so error_o is constant zero.
  assign error_o = credit_overflow;
`endif

endmodule

// File: tb/tb_flit_transmitter.sv
// Scoreboard bench for flit_transmitter: main instance with BUFFER_SIZE=8 and
// a second instance with BUFFER_SIZE=4 for the overflow scenario.
module tb_flit_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_o;
  logic       write_o;
  logic       credit_i = 1'b0;
  logic [3:0] credit_count_o;
  logic       error_o;

  logic [7:0] data4_i = '0;
  logic       valid4_i = 1'b0;
  logic       ready4_o;
  logic [7:0] data4_o;
  logic       write4_o;
  logic       credit4_i = 1'b0;
  logic [2:0] credit_count4_o;
  logic       error4_o;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         cyc = 0;
  int         wr_count = 0;
  int         first_wr = -1;
  int         last_wr = -1;

`ifdef FLIT_TRANSMITTER_CREDIT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  flit_transmitter #(.BUFFER_SIZE(8), .FLIT_SIZE(8)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .write_o(write_o), .credit_i(credit_i),
    .credit_count_o(credit_count_o), .error_o(error_o)
  );

  flit_transmitter #(.BUFFER_SIZE(4), .FLIT_SIZE(8)) dut4 (
    .clk(clk), .rst(rst), .data_i(data4_i), .valid_i(valid4_i), .ready_o(ready4_o),
    .data_o(data4_o), .write_o(write4_o), .credit_i(credit4_i),
    .credit_count_o(credit_count4_o), .error_o(error4_o)
  );

  always #5 clk = ~clk;

  // Every downstream write must carry the oldest accepted flit.
  always @(negedge clk) begin
    cyc++;
    if (write_o === 1'b1) begin
      wr_count++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write: data_o=%h written but none expected", data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_o !== mon_exp) begin
          failures++;
          $display("FAIL sb_data: data_o=%h expected %h", data_o, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Present one flit until accepted or the budget expires; called at posedge+1.
  task automatic send_flit(input logic [7:0] d, input int budget, output bit ok);
    ok = 1'b0;
    valid_i = 1'b1;
    data_i = d;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        exp_q.push_back(d);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if (write_o !== 1'b0) begin failures++; $display("FAIL reset_write: got %b want 0", write_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", data_o); end
    checks++; if (credit_count_o !== 4'd8) begin failures++; $display("FAIL reset_credits: got %0d want 8", credit_count_o); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", error_o); end
    checks++; if (credit_count4_o !== 3'd4) begin failures++; $display("FAIL reset_credits4: got %0d want 4", credit_count4_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_credit();
    bit ok;
    int wr0;
    wr0 = wr_count;
    first_wr = -1;
    for (int i = 1; i <= 9; i++) begin
      send_flit(8'(i), 4, ok);
      checks++; if (!ok) begin failures++; $display("FAIL zc_accept: flit %0d accepted=%0b want 1", i, ok); end
    end
    @(negedge clk);
    checks++; if (write_o !== 1'b0) begin failures++; $display("FAIL zc_write: got %b want 0", write_o); end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL zc_ready: got %b want 0", ready_o); end
    checks++; if (credit_count_o !== 4'd0) begin failures++; $display("FAIL zc_credits: got %0d want 0", credit_count_o); end
    checks++; if (data_o !== 8'h09) begin failures++; $display("FAIL zc_held: got %h want 09", data_o); end
    @(posedge clk); #1;
    checks++; if (wr_count - wr0 != 8) begin failures++; $display("FAIL zc_writes: got %0d want 8", wr_count - wr0); end
    checks++; if (last_wr - first_wr != 7) begin failures++; $display("FAIL zc_consecutive: span %0d want 7", last_wr - first_wr); end
    send_flit(8'h0A, 2, ok);
    checks++; if (ok) begin failures++; $display("FAIL zc_blocked: accepted=%0b want 0", ok); end
  endtask

  task automatic test_credit_return();
    int wr0;
    wr0 = wr_count;
    credit_i = 1'b1;
    @(posedge clk); #1;
    credit_i = 1'b0;
    @(negedge clk);
    checks++; if (write_o !== 1'b1) begin failures++; $display("FAIL cr_write: got %b want 1", write_o); end
    checks++; if (data_o !== 8'h09) begin failures++; $display("FAIL cr_data: got %h want 09", data_o); end
    checks++; if (credit_count_o !== 4'd1) begin failures++; $display("FAIL cr_count1: got %0d want 1", credit_count_o); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (write_o !== 1'b0) begin failures++; $display("FAIL cr_write_after: got %b want 0", write_o); end
    checks++; if (credit_count_o !== 4'd0) begin failures++; $display("FAIL cr_count0: got %0d want 0", credit_count_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL cr_ready: got %b want 1", ready_o); end
    @(posedge clk); #1;
    checks++; if (wr_count - wr0 != 1) begin failures++; $display("FAIL cr_writes: got %0d want 1", wr_count - wr0); end
  endtask

  task automatic test_same_edge();
    bit ok;
    credit_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 credit_i = 1'b0;
    checks++; if (credit_count_o !== 4'd3) begin failures++; $display("FAIL se_prefill: got %0d want 3", credit_count_o); end
    send_flit(8'h55, 2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL se_accept: accepted=%0b want 1", ok); end
    credit_i = 1'b1;
    @(negedge clk);
    checks++; if (write_o !== 1'b1) begin failures++; $display("FAIL se_write: got %b want 1", write_o); end
    @(posedge clk); #1;
    credit_i = 1'b0;
    checks++; if (credit_count_o !== 4'd3) begin failures++; $display("FAIL se_count: got %0d want 3", credit_count_o); end
    credit_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 credit_i = 1'b0;
    checks++; if (credit_count_o !== 4'd8) begin failures++; $display("FAIL se_refill: got %0d want 8", credit_count_o); end
  endtask

  task automatic test_back_to_back();
    int accepted, acc_first, acc_last, wr0, min_cr;
    bit prev_wr;
    accepted = 0; acc_first = -1; acc_last = -1; min_cr = 99; prev_wr = 1'b0;
    wr0 = wr_count;
    first_wr = -1;
    for (int c = 0; c < 400 && !(accepted == 100 && exp_q.size() == 0 && !prev_wr); c++) begin
      credit_i = prev_wr;
      valid_i = (accepted < 100);
      data_i = 8'(accepted + 16);
      @(negedge clk);
      if (valid_i && ready_o === 1'b1) begin
        exp_q.push_back(data_i);
        accepted++;
        if (acc_first < 0) acc_first = c;
        acc_last = c;
      end
      prev_wr = write_o;
      if (int'(credit_count_o) < min_cr) min_cr = int'(credit_count_o);
      @(posedge clk); #1;
    end
    credit_i = 1'b0;
    valid_i = 1'b0;
    checks++; if (accepted != 100) begin failures++; $display("FAIL bb_accepted: got %0d want 100", accepted); end
    checks++; if (acc_last - acc_first != 99) begin failures++; $display("FAIL bb_accept_rate: span %0d want 99", acc_last - acc_first); end
    checks++; if (wr_count - wr0 != 100) begin failures++; $display("FAIL bb_writes: got %0d want 100", wr_count - wr0); end
    checks++; if (last_wr - first_wr != 99) begin failures++; $display("FAIL bb_write_rate: span %0d want 99", last_wr - first_wr); end
    checks++; if (min_cr < 6) begin failures++; $display("FAIL bb_min_credit: got %0d want >=6", min_cr); end
    checks++; if (credit_count_o !== 4'd8) begin failures++; $display("FAIL bb_final_credits: got %0d want 8", credit_count_o); end
  endtask

  task automatic test_overflow();
    credit4_i = 1'b1;
    @(posedge clk); #1;
    credit4_i = 1'b0;
    @(negedge clk);
    checks++; if (credit_count4_o !== 3'd4) begin failures++; $display("FAIL ov_count: got %0d want 4", credit_count4_o); end
    checks++; if (error4_o !== EXP_ERR) begin failures++; $display("FAIL ov_error: got %b want %b", error4_o, EXP_ERR); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (error4_o !== EXP_ERR) begin failures++; $display("FAIL ov_sticky: got %b want %b", error4_o, EXP_ERR); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL ov_main_error: got %b want 0", error_o); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < 9; i++) begin
      send_flit(8'(8'hA0 + i), 4, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rm_accept: flit %0d accepted=%0b want 1", i, ok); end
    end
    checks++; if (credit_count_o !== 4'd0) begin failures++; $display("FAIL rm_pre_credits: got %0d want 0", credit_count_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if (write_o !== 1'b0) begin failures++; $display("FAIL rm_write: got %b want 0", write_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rm_ready: got %b want 1", ready_o); end
    checks++; if (credit_count_o !== 4'd8) begin failures++; $display("FAIL rm_credits: got %0d want 8", credit_count_o); end
    checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL rm_data: got %h want 00", data_o); end
    checks++; if (error4_o !== 1'b0) begin failures++; $display("FAIL rm_error4: got %b want 0", error4_o); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_zero_credit();
    test_credit_return();
    test_same_edge();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flit_transmitter.md
# flit_transmitter

Credit-based upstream sender that writes flits into a downstream `circular_buffer` input port of a neighbouring router. It keeps a credit counter mirroring the free slots of that buffer and only asserts the write strobe when a slot is guaranteed free. It accepts flits from the local output stage through a valid/ready handshake and holds one flit in an output register. Credits return as one pulse per flit the downstream buffer reads.

## Interface
Parameters:
- `BUFFER_SIZE`, 8: depth of the downstream buffer; initial and maximum credit count.
- `FLIT_SIZE`, 8: flit width in bits.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_i`  in  FLIT_SIZE  flit from the local output stage.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  transmitter can accept a flit this cycle.
- `data_o`  out  FLIT_SIZE  flit to the downstream buffer (`data_i` there).
- `write_o`  out  1  write strobe to the downstream buffer (`write_i` there).
- `credit_i`  in  1  one-cycle pulse per flit read downstream (mirrors the downstream `read_i`).
- `credit_count_o`  out  CW  current credit count, where CW = clogb2(BUFFER_SIZE+1).
- `error_o`  out  1  sticky credit-overflow flag (see Configuration).

## Operation
- State: `hold_valid` (1b), `hold_data` (FLIT_SIZE), `credits` (CW bits).
- `write_o = hold_valid & (credits != 0)`. `data_o = hold_data`.
- `ready_o = ~hold_valid | write_o`. This is combinational pass-through, so a new flit can load in the same cycle the held flit leaves.
- Accept: `valid_i & ready_o` loads `hold_data <= data_i` and sets `hold_valid <= 1`.
- Send with no accept: `hold_valid <= 0`.
- Credit update: `credits_next = credits - write_o + credit_i`.
  - A simultaneous send and credit leaves the count unchanged.
  - Arithmetic is unsigned in CW bits and never underflows, because `write_o` requires `credits != 0`.
- Overflow: `credit_i` while `credits == BUFFER_SIZE` and `write_o == 0` is a protocol violation.
  - The count saturates at BUFFER_SIZE.
  - Overflow handling per Configuration.
- Packet content is not interpreted; flits pass unmodified and in order.

## Timing
- Reset values:
  - `hold_valid = 0`, `hold_data = 0`, `credits = BUFFER_SIZE`, `error_o = 0`.
  - Hence `write_o = 0`, `data_o = 0`, `ready_o = 1`, `credit_count_o = BUFFER_SIZE`.
- Reset dominates all other inputs on the same edge. Reset mid-operation:
  - drops the held flit;
  - restores full credits;
  - is legal only when the downstream buffer is reset on the same edge.
- Latency: a flit accepted at edge N is driven with `write_o = 1` during cycle N..N+1 if credits are available, and is written downstream at edge N+1.
- Zero credits: the flit is held and `ready_o = 0`. A `credit_i` pulse at edge M makes `write_o = 1` in the cycle after M.
- Throughput: one flit per cycle while credits > 0.
- Credit loop: a sustained stream with round-trip credit latency L stalls only if L ≥ BUFFER_SIZE.
- `valid_i` may deassert without acceptance; the transmitter does not require valid stability.

## Configuration
- `FLIT_TRANSMITTER_CREDIT_CHECK_EN` defined:
  - a credit overflow sets `error_o` on the next edge;
  - `error_o` stays high until `rst`.
- Macro undefined:
  - `error_o` is tied to 0 and the detection logic is absent;
  - the counter still saturates at BUFFER_SIZE.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_SIZE` default;
  - `clogb2` function (the same definition the buffer uses for pointer widths);
  - credit-width helper.
- Sub-module `credit_counter`:
  - parameter `MAX` (initial value = maximum);
  - inputs `dec`, `inc`;
  - outputs `count`, `nonzero`, `overflow`;
  - synchronous active-high reset to MAX.
- The top level holds the one-flit output register and the handshake logic.

## Test plan
- Reset, then stream 8 flits 0x01..0x08 with `credit_i = 0` and BUFFER_SIZE = 8:
  - 8 writes on consecutive cycles, data in order;
  - then `write_o = 0`, `ready_o = 0`, `credit_count_o = 0`;
  - the 9th flit (0x09) is held.
- From the zero-credit state, pulse `credit_i` once:
  - exactly one write of 0x09 in the following cycle;
  - the count returns to 0.
- Continuous stream with `credit_i` looped back 1 cycle after each `write_o`:
  - 100 flits delivered at 1 flit/cycle;
  - the count never drops below 6.
- `credit_i` and `write_o` on the same edge at credits = 3: the count stays 3.
- With `FLIT_SIZE = 8` and `BUFFER_SIZE = 4`, pulse `credit_i` at full credits:
  - count stays 4;
  - `error_o = 1` when the macro is defined and remains set;
  - `error_o = 0` when it is undefined.
- Assert `rst` while a flit is held at credits = 0:
  - next cycle `write_o = 0`, `ready_o = 1`, `credit_count_o = BUFFER_SIZE`, `data_o = 0`.
